// File: rtl/regfile_writeback.sv
// Write-side sequencer for the split 16-bit register file: buffers results in a FIFO and
// emits them as 16-bit half writes. Optional decode hazard port behind RW_SCOREBOARD_EN.
module regfile_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wide,
    input  logic        ex_half,
    input  logic [31:0] ex_result,
    input  logic        rw_hold,
    output logic        rw_clken,
    output logic        rw_half,
    output logic [4:0]  rw_rd,
    output logic [15:0] rw_result,
    output logic        rw_busy
`ifdef RW_SCOREBOARD_EN
    ,
    input  logic [4:0]  de_rs,
    input  logic        de_half,
    output logic        de_pending
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic        wide;
        logic        half;
        logic [31:0] result;
    } entry_t;

    typedef enum logic {
        IDLE,
        HIGH
    } state_t;

    entry_t        mem [DEPTH];
    logic [AW:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW:0]   rd_ptr_reg, rd_ptr_next;
    state_t        state_reg, state_next;

    entry_t        head;
    entry_t        incoming;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          write_en;

    assign head     = mem[rd_ptr_reg[AW-1:0]];
    assign incoming = '{rd: ex_rd, wide: ex_wide, half: ex_half, result: ex_result};
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    // Extra MSB differs only when the writer has lapped the reader.
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign ex_ready = rst_n && !full;
    assign push     = ex_valid && ex_ready;

    always_comb begin
        pop        = 1'b0;
        write_en   = 1'b0;
        state_next = state_reg;
        if (rst_n && !empty && !rw_hold) begin
            if (state_reg == HIGH) begin
                pop        = 1'b1;
                write_en   = 1'b1;
                state_next = IDLE;
            end else if (head.rd == 5'd0) begin
                // r0 is hardwired zero in the register file, so just drop it.
                pop = 1'b1;
            end else if (head.wide) begin
                write_en   = 1'b1;
                state_next = HIGH;
            end else begin
                pop      = 1'b1;
                write_en = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_comb begin
        rw_clken  = write_en;
        rw_half   = 1'b0;
        rw_rd     = 5'd0;
        rw_result = 16'd0;
        if (rst_n && !empty) begin
            rw_rd = head.rd;
            if (state_reg == HIGH) begin
                rw_half   = 1'b1;
                rw_result = head.result[31:16];
            end else begin
                rw_half   = head.wide ? 1'b0 : head.half;
                rw_result = head.result[15:0];
            end
        end
    end

    assign rw_busy = rst_n && (!empty || (state_reg == HIGH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            state_reg  <= IDLE;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            state_reg  <= state_next;
        end
    end

    // Storage carries no reset; validity comes solely from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= incoming;
        end
    end

`ifdef RW_SCOREBOARD_EN
    logic [AW:0]      count;
    logic [DEPTH-1:0] pend_hit;

    assign count = wr_ptr_reg - rd_ptr_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        logic [AW-1:0] offset;
        logic          live;
        logic          covers;

        assign offset = AW'(gi) - rd_ptr_reg[AW-1:0];
        assign live   = ({1'b0, offset} < count);
        // Once the low half of the head has been written only the high half is outstanding.
        assign covers = mem[gi].wide ?
                        !((offset == '0) && (state_reg == HIGH) && !de_half) :
                        (mem[gi].half == de_half);
        assign pend_hit[gi] = live && covers && (mem[gi].rd == de_rs);
    end

    assign de_pending = rst_n && (de_rs != 5'd0) && (|pend_hit);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-based model
// of pending results; scoreboard checks are built when RW_SCOREBOARD_EN is defined.
module tb_regfile_writeback;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_wide;
    logic        ex_half;
    logic [31:0] ex_result;
    logic        rw_hold;
    logic        rw_clken;
    logic        rw_half;
    logic [4:0]  rw_rd;
    logic [15:0] rw_result;
    logic        rw_busy;
`ifdef RW_SCOREBOARD_EN
    logic [4:0]  de_rs;
    logic        de_half;
    logic        de_pending;
`endif

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_rd     (ex_rd),
        .ex_wide   (ex_wide),
        .ex_half   (ex_half),
        .ex_result (ex_result),
        .rw_hold   (rw_hold),
        .rw_clken  (rw_clken),
        .rw_half   (rw_half),
        .rw_rd     (rw_rd),
        .rw_result (rw_result),
        .rw_busy   (rw_busy)
`ifdef RW_SCOREBOARD_EN
        ,
        .de_rs     (de_rs),
        .de_half   (de_half),
        .de_pending(de_pending)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wide;
        logic        half;
        logic [31:0] result;
    } entry_t;

    // Results not yet fully written, oldest first; low_done marks a wide head whose low half is out.
    entry_t q[$];
    bit     low_done;
    bit     m_ready;

    int n_checks;
    int n_pass;

    logic        samp_ready, samp_clken, samp_half, samp_busy;
    logic [4:0]  samp_rd;
    logic [15:0] samp_result;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pending(input logic [4:0] rs, input logic hf);
        bit p;
        p = 1'b0;
        if (rst_n && rs != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == rs && (q[i].wide || q[i].half == hf) &&
                    !(i == 0 && low_done && hf == 1'b0)) begin
                    p = 1'b1;
                end
            end
        end
        return p;
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit          e_clken, e_busy;
        bit          e_half;
        logic [4:0]  e_rd;
        logic [15:0] e_result;
        entry_t      h;
        @(negedge clk);
        m_ready  = rst_n && (q.size() < DEPTH);
        e_busy   = rst_n && (q.size() > 0);
        e_clken  = 1'b0;
        e_half   = 1'b0;
        e_rd     = 5'd0;
        e_result = 16'd0;
        if (rst_n && q.size() > 0) begin
            h       = q[0];
            e_rd    = h.rd;
            e_clken = !rw_hold && (h.rd != 5'd0);
            if (low_done) begin
                e_half   = 1'b1;
                e_result = h.result[31:16];
            end else begin
                e_half   = h.wide ? 1'b0 : h.half;
                e_result = h.result[15:0];
            end
        end
        samp_ready  = ex_ready;
        samp_clken  = rw_clken;
        samp_half   = rw_half;
        samp_busy   = rw_busy;
        samp_rd     = rw_rd;
        samp_result = rw_result;
        check_value("ex_ready", {31'd0, ex_ready}, {31'd0, m_ready});
        check_value("rw_busy", {31'd0, rw_busy}, {31'd0, e_busy});
        check_value("rw_clken", {31'd0, rw_clken}, {31'd0, e_clken});
        if (e_clken || !e_busy) begin
            check_value("rw_rd", {27'd0, rw_rd}, {27'd0, e_rd});
            check_value("rw_half", {31'd0, rw_half}, {31'd0, e_half});
            check_value("rw_result", {16'd0, rw_result}, {16'd0, e_result});
        end
        if (e_clken) begin
            $display("write rd=%0d half=%0d data=%04h", e_rd, e_half, e_result);
        end
`ifdef RW_SCOREBOARD_EN
        check_value("de_pending", {31'd0, de_pending}, {31'd0, model_pending(de_rs, de_half)});
`endif
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            low_done = 1'b0;
        end else begin
            if (q.size() > 0 && !rw_hold) begin
                if (q[0].rd == 5'd0) begin
                    void'(q.pop_front());
                end else if (q[0].wide && !low_done) begin
                    low_done = 1'b1;
                end else begin
                    void'(q.pop_front());
                    low_done = 1'b0;
                end
            end
            if (ex_valid && m_ready) begin
                q.push_back('{rd: ex_rd, wide: ex_wide, half: ex_half, result: ex_result});
            end
        end
        #1;
    endtask

    task automatic drive_push(input logic [4:0] rd, input logic wide, input logic hf,
                              input logic [31:0] res);
        ex_valid  = 1'b1;
        ex_rd     = rd;
        ex_wide   = wide;
        ex_half   = hf;
        ex_result = res;
    endtask

`ifdef RW_SCOREBOARD_EN
    task automatic probe(input logic [4:0] rs, input logic hf, input logic exp);
        de_rs   = rs;
        de_half = hf;
        #1;
        check_value("de_probe", {31'd0, de_pending}, {31'd0, exp});
        check_value("de_model", {31'd0, de_pending}, {31'd0, model_pending(rs, hf)});
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        low_done  = 1'b0;
        rst_n     = 1'b0;
        ex_valid  = 1'b0;
        ex_rd     = 5'd0;
        ex_wide   = 1'b0;
        ex_half   = 1'b0;
        ex_result = 32'd0;
        rw_hold   = 1'b0;
`ifdef RW_SCOREBOARD_EN
        de_rs     = 5'd0;
        de_half   = 1'b0;
`endif
        cycle();
        cycle();
        check_value("reset_ready", {31'd0, samp_ready}, 32'd0);
        check_value("reset_busy", {31'd0, samp_busy}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a wide write.
        drive_push(5'd3, 1'b1, 1'b0, 32'hDEAD_BEEF);
        cycle();
        check_value("post_reset_ready", {31'd0, samp_ready}, 32'd1);
        ex_valid = 1'b0;
        cycle();
        check_value("midrst_low", {16'd0, samp_result}, 32'h0000_BEEF);
        rst_n = 1'b0;
        cycle();
        check_value("midrst_clken", {31'd0, samp_clken}, 32'd0);
        check_value("midrst_busy", {31'd0, samp_busy}, 32'd0);
        check_value("midrst_ready", {31'd0, samp_ready}, 32'd0);
        rst_n = 1'b1;
        cycle();
        check_value("rel_ready", {31'd0, samp_ready}, 32'd1);
        check_value("rel_clken", {31'd0, samp_clken}, 32'd0);

        // Narrow results back to back.
        drive_push(5'd5, 1'b0, 1'b0, 32'h0000_1234);
        cycle();
        drive_push(5'd6, 1'b0, 1'b1, 32'h0000_000A);
        cycle();
        check_value("nb1_rd", {27'd0, samp_rd}, 32'd5);
        drive_push(5'd7, 1'b0, 1'b0, 32'h0000_FFFF);
        cycle();
        check_value("nb2_half", {31'd0, samp_half}, 32'd1);
        ex_valid = 1'b0;
        cycle();
        check_value("nb3_result", {16'd0, samp_result}, 32'h0000_FFFF);
        cycle();

        // Wide result split into two half writes.
        drive_push(5'd9, 1'b1, 1'b0, 32'h000A_BCDE);
        cycle();
        ex_valid = 1'b0;
        cycle();
        check_value("wide_lo", {15'd0, samp_half, samp_result}, 32'h0000_BCDE);
        cycle();
        check_value("wide_hi", {15'd0, samp_half, samp_result}, 32'h0001_000A);
        check_value("wide_busy", {31'd0, samp_busy}, 32'd1);
        cycle();
        check_value("wide_idle", {31'd0, samp_busy}, 32'd0);

        // Fill the FIFO under hold, then drain in order.
        rw_hold = 1'b1;
        drive_push(5'd10, 1'b1, 1'b0, 32'hAAAA_5555);
        cycle();
        drive_push(5'd11, 1'b1, 1'b0, 32'h1357_2468);
        cycle();
        drive_push(5'd13, 1'b0, 1'b1, 32'h0000_7777);
        cycle();
        check_value("full_ready", {31'd0, samp_ready}, 32'd0);
        rw_hold = 1'b0;
        cycle();
        cycle();
        check_value("full_pop_ready", {31'd0, samp_ready}, 32'd0);
        cycle();
        check_value("full_rise_ready", {31'd0, samp_ready}, 32'd1);
        ex_valid = 1'b0;
        repeat (5) cycle();

        // Hold during the high half, then a wide write to r0.
        drive_push(5'd4, 1'b1, 1'b0, 32'h1111_2222);
        cycle();
        ex_valid = 1'b0;
        cycle();
        rw_hold = 1'b1;
        repeat (3) begin
            cycle();
            check_value("hold_clken", {31'd0, samp_clken}, 32'd0);
        end
        rw_hold = 1'b0;
        cycle();
        check_value("hold_resume", {15'd0, samp_half, samp_result}, 32'h0001_1111);
        drive_push(5'd0, 1'b1, 1'b0, 32'h9999_8888);
        cycle();
        ex_valid = 1'b0;
        cycle();
        check_value("r0_clken", {31'd0, samp_clken}, 32'd0);
        cycle();
        check_value("r0_empty", {31'd0, samp_busy}, 32'd0);

`ifdef RW_SCOREBOARD_EN
        rw_hold = 1'b1;
        drive_push(5'd12, 1'b1, 1'b0, 32'h0001_0002);
        cycle();
        ex_valid = 1'b0;
        probe(5'd12, 1'b0, 1'b1);
        probe(5'd12, 1'b1, 1'b1);
        probe(5'd13, 1'b0, 1'b0);
        probe(5'd0, 1'b0, 1'b0);
        rw_hold = 1'b0;
        cycle();
        probe(5'd12, 1'b0, 1'b0);
        probe(5'd12, 1'b1, 1'b1);
        cycle();
        probe(5'd12, 1'b0, 1'b0);
        probe(5'd12, 1'b1, 1'b0);
`endif

        // Random traffic with small register range to exercise r0 and hazards.
        for (int n = 0; n < 600; n++) begin
            ex_valid  = ($urandom_range(0, 9) < 6);
            ex_rd     = 5'($urandom_range(0, 7));
            ex_wide   = 1'($urandom_range(0, 1));
            ex_half   = 1'($urandom_range(0, 1));
            ex_result = $urandom;
            rw_hold   = ($urandom_range(0, 4) == 0);
            rst_n     = ($urandom_range(0, 79) != 0);
`ifdef RW_SCOREBOARD_EN
            de_rs     = 5'($urandom_range(0, 7));
            de_half   = 1'($urandom_range(0, 1));
`endif
            cycle();
        end
        rst_n    = 1'b1;
        ex_valid = 1'b0;
        rw_hold  = 1'b0;
        repeat (6) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side sequencer for the split 16-bit register file.
- Accepts completed results from the execute/memory stage through a valid/ready handshake and buffers them in a small FIFO.
- Drives the register file's rw_clken / rw_half / rw_rd / rw_result write port.
- 32-bit ("wide") results are written as two 16-bit half writes on consecutive cycles, low half first; single-half results take one cycle.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  result available from execute/memory stage
- ex_ready  out  1  FIFO can accept a result this cycle
- ex_rd  in  5  destination register
- ex_wide  in  1  1 = write both halves from ex_result[31:0]; 0 = single half
- ex_half  in  1  target half when ex_wide=0 (0 = low bank, 1 = high bank)
- ex_result  in  32  result data; only [15:0] used when ex_wide=0
- rw_hold  in  1  freeze the write port this cycle (port contention)
- rw_clken  out  1  register file write enable
- rw_half  out  1  bank select for the current write
- rw_rd  out  5  write address
- rw_result  out  16  write data
- rw_busy  out  1  FIFO non-empty or wide write in progress

Behaviour:
- Reset:
  - rst_n low at a rising edge empties the FIFO, forces the FSM to IDLE and discards any half-finished wide write.
  - While rst_n is low: ex_ready=0, rw_clken=0, rw_busy=0, rw_half=0, rw_rd=0, rw_result=0.
  - ex_ready returns to 1 in the first cycle after reset is released.
- Accept:
  - Transfer occurs at an edge where ex_valid & ex_ready.
  - ex_ready = !full, computed without regard to a same-cycle pop (no push-through when full).
  - ex_* are ignored when ex_ready=0.
- FIFO:
  - Circular pointers with wrap-around at DEPTH; one extra pointer bit distinguishes full from empty.
  - Each entry holds {rd, wide, half, result[31:0]}.
  - A simultaneous push and pop when not full keeps the count unchanged.
- rw_* outputs are combinational from the FIFO head and FSM state.
- Latency: an entry pushed at edge N drives rw_clken=1 in cycle N+1 and commits at edge N+1 (assuming rw_hold=0 and the FIFO was empty before the push).
- FSM states: IDLE, HIGH.
  - IDLE, head valid, wide=0: rw_clken=1, rw_half=head.half, rw_result=head.result[15:0]. Pop at the edge; stay in IDLE.
  - IDLE, head valid, wide=1: rw_clken=1, rw_half=0, rw_result=head.result[15:0]. Go to HIGH; no pop.
  - HIGH: rw_clken=1, rw_half=1, rw_result=head.result[31:16]. Pop at the edge; go to IDLE.
  - rw_rd = head.rd in both states.
- Register 0: head.rd==0 pops in one cycle with rw_clken=0, even when wide. The register file already reads r0 as zero.
- rw_hold=1: rw_clken=0, no pop, FSM state held. A wide write resumes at the half it stopped on. Pushes are still accepted.
- Throughput: one narrow result per cycle; one wide result per two cycles.
- rw_busy = FIFO non-empty OR state==HIGH.
- Outputs are don't-care-free: when idle, rw_half=0, rw_rd=0, rw_result=0.

Optional Feature:
- Macro: RW_SCOREBOARD_EN.
- When defined, adds ports:
  - de_rs in 5
  - de_half in 1
  - de_pending out 1
- de_pending is combinational. It is 1 when any valid FIFO entry has rd==de_rs, de_rs!=0, and the entry's writes cover the queried half: wide=1, or half==de_half.
- The head entry in state HIGH still counts as pending for de_half=1, but no longer for de_half=0.
- Decode uses de_pending to stall on a read-after-write hazard.
- When not defined: ports absent, no compare logic.

Test Plan:
- Reset mid-wide-write: push rd=3, wide, 0xDEAD_BEEF; assert rst_n=0 in the HIGH cycle -> no high write occurs, rw_busy=0, ex_ready=0 during reset and 1 the cycle after release.
- Narrow back-to-back: pushes on consecutive cycles of (rd=5, half=0, 0x1234), (rd=6, half=1, 0x000A), (rd=7, half=0, 0xFFFF) -> three consecutive rw_clken cycles with matching rw_rd/rw_half/rw_result, starting one cycle after the first push.
- Wide split: push rd=9, wide, 0x000A_BCDE -> cycle 1: rw_half=0, rw_result=0xBCDE; cycle 2: rw_half=1, rw_result=0x000A; rw_busy falls after the second write.
- Full/backpressure with DEPTH=2: hold rw_hold=1 and push 2 wide entries -> ex_ready=0 with a third ex_valid pending; release rw_hold -> ex_ready rises in the cycle after the first pop; the third entry is accepted and written after the first two, in order.
- Hold mid-wide plus r0: push rd=4 wide 0x1111_2222, assert rw_hold in the HIGH cycle for 3 cycles -> the high write 0x1111 occurs after release. Then push rd=0 wide -> one cycle, rw_clken=0, FIFO empties.
- RW_SCOREBOARD_EN: push rd=12, wide, 0x0001_0002 with rw_hold=1 -> de_pending=1 for (12,0) and (12,1), 0 for (13,0) and (0,0). Release hold -> after the low write, de_pending=0 for (12,0) and 1 for (12,1); after the high write, 0 for both.
